// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: colour bars, checkerboard and a bouncing
// square, with programmable timing, sync polarity, data enable and frame-start strobe.
module vga_pattern_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter bit SYNC_POL = 1'b0,
  parameter int RGB_W    = 4,
  parameter int SQ       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       i_mode,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de,
  output logic [RGB_W-1:0] o_r,
  output logic [RGB_W-1:0] o_g,
  output logic [RGB_W-1:0] o_b,
  output logic             o_frame_start
);

  localparam int H_TOT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_BEG = H_SYNC + H_BACK;
  localparam int V_BEG = V_SYNC + V_BACK;
  localparam int HW    = ($clog2(H_TOT + 1) > 6) ? $clog2(H_TOT + 1) : 6;
  localparam int VW    = ($clog2(V_TOT + 1) > 6) ? $clog2(V_TOT + 1) : 6;
  localparam int HW1   = HW + 1;
  localparam int VW1   = VW + 1;
  localparam int BW    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int BH    = (V_ACTIVE / 8 > 0) ? V_ACTIVE / 8 : 1;

  localparam logic [HW-1:0] HC_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] HC_SYNC = HW'(H_SYNC);
  localparam logic [HW-1:0] HC_BEG  = HW'(H_BEG);
  localparam logic [HW-1:0] HC_END  = HW'(H_BEG + H_ACTIVE);
  localparam logic [HW-1:0] BX_LAST = HW'(BW - 1);
  localparam logic [HW-1:0] SX_MAX  = HW'(H_ACTIVE - SQ);
  localparam logic [HW:0]   SQ_X    = HW1'(SQ);

  localparam logic [VW-1:0] VC_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] VC_SYNC = VW'(V_SYNC);
  localparam logic [VW-1:0] VC_BEG  = VW'(V_BEG);
  localparam logic [VW-1:0] VC_END  = VW'(V_BEG + V_ACTIVE);
  localparam logic [VW-1:0] BY_LAST = VW'(BH - 1);
  localparam logic [VW-1:0] SY_MAX  = VW'(V_ACTIVE - SQ);
  localparam logic [VW:0]   SQ_Y    = VW1'(SQ);

  logic          w_pix_ce;
  logic [HW-1:0] r_hc;
  logic [VW-1:0] r_vc;
  logic [HW-1:0] w_hc_nxt;
  logic [VW-1:0] w_vc_nxt;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_origin;
  logic          w_h_act;
  logic          w_v_act;
  logic          w_act;
  logic [HW-1:0] w_x;
  logic [VW-1:0] w_y;

  logic [HW-1:0] r_bxc;
  logic [VW-1:0] r_byc;
  logic [2:0]    r_bx;
  logic [2:0]    r_by;
  logic [2:0]    w_hbar;
  logic [2:0]    w_vbar;

  logic [HW-1:0] r_sx;
  logic [VW-1:0] r_sy;
  logic          r_dx;
  logic          r_dy;
  logic          w_in_sq;

  logic [2:0]    r_mode;
  logic [2:0]    w_c;

  logic             r_hsync;
  logic             r_vsync;
  logic             r_de;
  logic [RGB_W-1:0] r_r;
  logic [RGB_W-1:0] r_g;
  logic [RGB_W-1:0] r_b;
  logic             r_frame_start;

  generate
    if (CLK_DIV > 1) begin : g_div
      localparam int DW = $clog2(CLK_DIV);
      localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
      logic [DW-1:0] r_cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          r_cnt <= '0;
        else if (r_cnt == DIV_LAST)
          r_cnt <= '0;
        else
          r_cnt <= r_cnt + 1'b1;
      end

      assign w_pix_ce = (r_cnt == DIV_LAST);
    end else begin : g_nodiv
      assign w_pix_ce = 1'b1;
    end
  endgenerate

  assign w_h_last = (r_hc == HC_LAST);
  assign w_v_last = (r_vc == VC_LAST);
  assign w_hc_nxt = w_h_last ? '0 : r_hc + 1'b1;
  assign w_vc_nxt = w_v_last ? '0 : r_vc + 1'b1;
  assign w_origin = (r_hc == '0) && (r_vc == '0);
  assign w_h_act  = (r_hc >= HC_BEG) && (r_hc < HC_END);
  assign w_v_act  = (r_vc >= VC_BEG) && (r_vc < VC_END);
  assign w_act    = w_h_act && w_v_act;
  assign w_x      = r_hc - HC_BEG;
  assign w_y      = r_vc - VC_BEG;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_pix_ce) begin
      r_hc <= w_hc_nxt;
      if (w_h_last)
        r_vc <= w_vc_nxt;
    end
  end

  // Bar indices track x/BW and y/BH with sub-counters, restarting one step before
  // the active region begins and saturating at 7 for any remainder pixels/lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bxc <= '0;
      r_bx  <= '0;
      r_byc <= '0;
      r_by  <= '0;
    end else if (w_pix_ce) begin
      if (w_hc_nxt == HC_BEG) begin
        r_bxc <= '0;
        r_bx  <= '0;
      end else if (w_h_act) begin
        if (r_bxc == BX_LAST) begin
          r_bxc <= '0;
          if (r_bx != 3'd7)
            r_bx <= r_bx + 3'd1;
        end else begin
          r_bxc <= r_bxc + 1'b1;
        end
      end
      if (w_h_last) begin
        if (w_vc_nxt == VC_BEG) begin
          r_byc <= '0;
          r_by  <= '0;
        end else if (w_v_act) begin
          if (r_byc == BY_LAST) begin
            r_byc <= '0;
            if (r_by != 3'd7)
              r_by <= r_by + 3'd1;
          end else begin
            r_byc <= r_byc + 1'b1;
          end
        end
      end
    end
  end

  // The square steps on the last pixel of each frame, so the first frame after
  // reset shows it at the origin; hitting an edge costs one frame to reverse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sx <= '0;
      r_sy <= '0;
      r_dx <= 1'b1;
      r_dy <= 1'b1;
    end else if (w_pix_ce && w_h_last && w_v_last) begin
      if (r_dx) begin
        if (r_sx == SX_MAX) r_dx <= 1'b0;
        else                r_sx <= r_sx + 1'b1;
      end else begin
        if (r_sx == '0)     r_dx <= 1'b1;
        else                r_sx <= r_sx - 1'b1;
      end
      if (r_dy) begin
        if (r_sy == SY_MAX) r_dy <= 1'b0;
        else                r_sy <= r_sy + 1'b1;
      end else begin
        if (r_sy == '0)     r_dy <= 1'b1;
        else                r_sy <= r_sy - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_mode <= 3'd0;
    else if (w_pix_ce && w_origin)
      r_mode <= i_mode;
  end

  assign w_hbar  = ~r_by;
  assign w_vbar  = ~r_bx;
  assign w_in_sq = ({1'b0, w_x} >= {1'b0, r_sx}) && ({1'b0, w_x} < ({1'b0, r_sx} + SQ_X)) &&
                   ({1'b0, w_y} >= {1'b0, r_sy}) && ({1'b0, w_y} < ({1'b0, r_sy} + SQ_Y));

  always_comb begin
    w_c = 3'd0;
    case (r_mode)
      3'd0:    w_c = w_hbar;
      3'd1:    w_c = w_vbar;
      3'd2:    w_c = w_hbar ^ w_vbar;
      3'd3:    w_c = ~(w_hbar ^ w_vbar);
      3'd4:    w_c = (w_x[5] ^ w_y[5]) ? 3'd7 : 3'd0;
      3'd5:    w_c = w_in_sq ? 3'd7 : 3'd1;
      default: w_c = 3'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_de    <= 1'b0;
      r_r     <= '0;
      r_g     <= '0;
      r_b     <= '0;
    end else if (w_pix_ce) begin
      r_hsync <= (r_hc < HC_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_vsync <= (r_vc < VC_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_de    <= w_act;
      r_r     <= w_act ? {RGB_W{w_c[2]}} : '0;
      r_g     <= w_act ? {RGB_W{w_c[1]}} : '0;
      r_b     <= w_act ? {RGB_W{w_c[0]}} : '0;
    end
  end

  // Evaluated every clock so the strobe lasts one clock even when CLK_DIV > 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_frame_start <= 1'b0;
    else
      r_frame_start <= w_pix_ce && w_origin;
  end

  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_de          = r_de;
  assign o_r           = r_r;
  assign o_g           = r_g;
  assign o_b           = r_b;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on a shrunken raster: a frame-level reference
// model predicts every clock's outputs, and a separate monitor compares the DUT.
module tb_vga_pattern_gen;

  localparam int CLK_DIV  = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BACK   = 2;
  localparam int H_ACTIVE = 45;
  localparam int H_FRONT  = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 2;
  localparam int V_ACTIVE = 42;
  localparam int V_FRONT  = 1;
  localparam bit SYNC_POL = 1'b1;
  localparam int RGB_W    = 4;
  localparam int SQ       = 40;

  localparam int HT         = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int VT         = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HBEG       = H_SYNC + H_BACK;
  localparam int VBEG       = V_SYNC + V_BACK;
  localparam int BW         = H_ACTIVE / 8;
  localparam int BH         = V_ACTIVE / 8;
  localparam int FRAME_PIX  = HT * VT;
  localparam int FRAME_CLKS = FRAME_PIX * CLK_DIV;

  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             de;
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
    logic             fs;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [2:0]       mode;
  logic             o_hsync;
  logic             o_vsync;
  logic             o_de;
  logic [RGB_W-1:0] o_r;
  logic [RGB_W-1:0] o_g;
  logic [RGB_W-1:0] o_b;
  logic             o_frame_start;

  exp_t expQ[$];
  exp_t held;
  int   k;
  int   curMode;
  int   errors;
  int   checks;
  int   edgeCnt = 0;
  int   lastFs  = -1;
  int   modePlan[9] = '{1, 5, 2, 3, 4, 5, 5, 7, 5};

  vga_pattern_gen #(
    .CLK_DIV(CLK_DIV), .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE),
    .H_FRONT(H_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE),
    .V_FRONT(V_FRONT), .SYNC_POL(SYNC_POL), .RGB_W(RGB_W), .SQ(SQ)
  ) dut (
    .clk(clk), .reset(reset), .i_mode(mode),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
    .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_frame_start(o_frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t rstExp();
    exp_t e;
    e    = '0;
    e.hs = !SYNC_POL;
    e.vs = !SYNC_POL;
    return e;
  endfunction

  // Square position after f frame-boundary steps, bouncing inside [0, maxv].
  function automatic int sqPos(input int f, input int maxv);
    int s;
    int d;
    s = 0;
    d = 1;
    for (int i = 0; i < f; i++) begin
      if (s + d < 0 || s + d > maxv) d = -d;
      else                           s = s + d;
    end
    return s;
  endfunction

  function automatic exp_t pixelModel(input int p, input int mq);
    exp_t e;
    int hc, vc, line, f, x, y, hbar, vbar, c, sx, sy;
    bit act;
    hc   = p % HT;
    line = p / HT;
    vc   = line % VT;
    f    = line / VT;
    x    = hc - HBEG;
    y    = vc - VBEG;
    act  = (x >= 0) && (x < H_ACTIVE) && (y >= 0) && (y < V_ACTIVE);
    vbar = 7 - ((x / BW > 7) ? 7 : x / BW);
    hbar = 7 - ((y / BH > 7) ? 7 : y / BH);
    sx   = sqPos(f, H_ACTIVE - SQ);
    sy   = sqPos(f, V_ACTIVE - SQ);
    case (mq)
      0:       c = hbar;
      1:       c = vbar;
      2:       c = hbar ^ vbar;
      3:       c = ~(hbar ^ vbar) & 7;
      4:       c = ((((x / 32) ^ (y / 32)) & 1) != 0) ? 7 : 0;
      5:       c = (x >= sx && x < sx + SQ && y >= sy && y < sy + SQ) ? 7 : 1;
      default: c = 0;
    endcase
    if (!act) c = 0;
    e.hs = (hc < H_SYNC) ? SYNC_POL : !SYNC_POL;
    e.vs = (vc < V_SYNC) ? SYNC_POL : !SYNC_POL;
    e.de = act;
    e.r  = ((c & 4) != 0) ? {RGB_W{1'b1}} : {RGB_W{1'b0}};
    e.g  = ((c & 2) != 0) ? {RGB_W{1'b1}} : {RGB_W{1'b0}};
    e.b  = ((c & 1) != 0) ? {RGB_W{1'b1}} : {RGB_W{1'b0}};
    e.fs = (hc == 0) && (vc == 0);
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock: predict the outputs after this edge, then return at the falling edge.
  task automatic applyStimulus();
    exp_t e;
    int   p;
    @(posedge clk);
    if (reset) begin
      k       = 0;
      curMode = 0;
      held    = rstExp();
      e       = held;
    end else begin
      k++;
      if (k % CLK_DIV == 0) begin
        p    = k / CLK_DIV - 1;
        held = pixelModel(p, curMode);
        if (p % FRAME_PIX == 0) curMode = int'(mode);
        e = held;
      end else begin
        e    = held;
        e.fs = 1'b0;
      end
    end
    expQ.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (reset) edgeCnt <= 0;
    else       edgeCnt <= edgeCnt + 1;
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) lastFs = -1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("hsync", int'(o_hsync), int'(e.hs));
        checkOutput("vsync", int'(o_vsync), int'(e.vs));
        checkOutput("de", int'(o_de), int'(e.de));
        checkOutput("red", int'(o_r), int'(e.r));
        checkOutput("green", int'(o_g), int'(e.g));
        checkOutput("blue", int'(o_b), int'(e.b));
        checkOutput("frame_start", int'(o_frame_start), int'(e.fs));
      end
      if (o_frame_start && !reset) begin
        if (lastFs < 0) checkOutput("first_frame_start_delay", edgeCnt, CLK_DIV);
        else            checkOutput("frame_start_period", edgeCnt - lastFs, FRAME_CLKS);
        lastFs = edgeCnt;
      end
    end
  end

  initial begin
    int chg;
    int glitchAt;
    errors  = 0;
    checks  = 0;
    k       = 0;
    curMode = 0;
    held    = rstExp();
    reset   = 1'b1;
    mode    = 3'd0;
    repeat (3) applyStimulus();
    reset = 1'b0;

    // Each frame: a random glitch value mid-frame, then the planned mode for the next frame.
    for (int f = 0; f < 9; f++) begin
      chg      = int'($urandom_range(FRAME_CLKS * 3 / 4, FRAME_CLKS / 4));
      glitchAt = chg / 2;
      for (int c = 0; c < FRAME_CLKS; c++) begin
        applyStimulus();
        if (c == glitchAt) mode = 3'($urandom_range(7, 0));
        if (c == chg)      mode = 3'(modePlan[f]);
      end
    end

    repeat (CLK_DIV * (1 + 20 * HT + 30)) applyStimulus();
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_hsync", int'(o_hsync), int'(!SYNC_POL));
    checkOutput("async_reset_vsync", int'(o_vsync), int'(!SYNC_POL));
    checkOutput("async_reset_de", int'(o_de), 0);
    checkOutput("async_reset_rgb", int'({o_r, o_g, o_b}), 0);
    checkOutput("async_reset_frame_start", int'(o_frame_start), 0);
    repeat (3) applyStimulus();
    reset = 1'b0;
    mode  = 3'($urandom_range(5, 0));
    repeat (FRAME_CLKS + 4 * CLK_DIV) applyStimulus();

    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised VGA timing and test-pattern generator, the next generation of the board's fixed 640x480 3-bit colour-bar source. It derives a pixel clock enable from the system clock, generates programmable horizontal and vertical timing with selectable sync polarity, and drives per-channel RGB of configurable depth. It adds a checkerboard mode, a bouncing-square animation, frame-synchronous mode switching, a data-enable output and a frame-start strobe. It sits directly in front of the board's VGA connector/DAC.

## Interface
- CLK_DIV, 2: system clocks per pixel, at least 1
- H_SYNC, 96 / H_BACK, 48 / H_ACTIVE, 640 / H_FRONT, 16: horizontal pixels per segment
- V_SYNC, 2 / V_BACK, 33 / V_ACTIVE, 480 / V_FRONT, 10: vertical lines per segment
- SYNC_POL, 0: active level of hsync/vsync (0 = active-low)
- RGB_W, 4: bits per colour channel
- SQ, 32: bouncing-square edge length in pixels, less than V_ACTIVE

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- mode  in  3  pattern select, sampled at frame start
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  active-video flag
- r, g, b  out  RGB_W each  colour channels
- frame_start  out  1  one-clk pulse at first pixel of frame

## Operation
- Divider: cnt runs 0..CLK_DIV-1; pix_ce = (cnt == CLK_DIV-1). All logic below advances only on pix_ce.
- Counters: hc runs 0..H_TOT-1, where H_TOT = sum of H_*. vc increments when hc wraps, and runs 0..V_TOT-1.
- Sync is active while hc < H_SYNC, or while vc < V_SYNC.
- Active region: hc in [H_SYNC+H_BACK, +H_ACTIVE) and vc in [V_SYNC+V_BACK, +V_ACTIVE).
- x and y are active-relative coordinates.
- Outside the active region, r/g/b = 0.
- Colour code c[2:0] maps to channels as follows: r = {RGB_W{c[2]}}, g = {RGB_W{c[1]}}, b = {RGB_W{c[0]}}.
- Bar width is BW = H_ACTIVE/8; bar height is BH = V_ACTIVE/8 (integer division). Bar index is saturated at 7.
- vbar = 7 - min(x/BW, 7); hbar = 7 - min(y/BH, 7).
- Implement bar indices with running counters, not dividers.
- Modes (latched mode_q):
  - 0: c = hbar
  - 1: c = vbar
  - 2: c = hbar ^ vbar
  - 3: c = ~(hbar ^ vbar)
  - 4: checker, c = 7 when x[5] ^ y[5], else 0
  - 5: square, c = 7 (white) inside [sx, sx+SQ) x [sy, sy+SQ), else 3'b001 (blue)
  - 6, 7: c = 0 (black)
- mode_q loads mode only when hc = 0 and vc = 0 are processed. A change mid-frame therefore never tears.
- Square motion, once per frame at the same point:
  - sx += dx and sy += dy, with dx, dy each ±1.
  - dx flips when the next sx would leave [0, H_ACTIVE-SQ]; in that frame sx is not moved and holds the edge value.
  - dy behaves the same against [0, V_ACTIVE-SQ].
- The square animates in every mode. It is only visible in mode 5.

## Timing
- Reset (async) values:
  - cnt, hc, vc = 0; mode_q = 0.
  - sx = sy = 0; dx = dy = +1.
  - hsync = vsync = !SYNC_POL (inactive).
  - de = 0; r/g/b = 0; frame_start = 0.
- First pix_ce occurs CLK_DIV clocks after reset deasserts.
- Outputs are registered on pix_ce, giving a latency of one pixel: outputs show the state of the (hc, vc) held before that pix_ce.
- Sync and colour are aligned on the same pixel.
- frame_start is high for exactly one clk, on the pix_ce that presents hc = 0, vc = 0. Its period is H_TOT·V_TOT·CLK_DIV clocks.
- Wrap: hc = H_TOT-1 goes to 0. vc advances only on that pix_ce, and vc = V_TOT-1 goes to 0 at the same time.
- CLK_DIV = 1: pix_ce is constantly high.
- Reset asserted mid-frame: all outputs go to reset values immediately, and the timing restarts at (0,0).

## Test plan
- Defaults, run 2 frames:
  - hsync low for 192 clks within every 1600-clk period.
  - vsync low for 2 lines within every 525 lines.
  - frame_start period is 840000 clks.
- Mode 0: de high for 640 pixels per line, on 480 lines.
  - First active line, rgb = F/F/F.
  - Line y = 60 (BH = 60) has c = 6: r = F, g = F, b = 0.
  - Line y = 479 has c = 0.
- Mode change 0 to 1 at mid-frame: current frame stays horizontal bars; vertical bars appear from the next frame_start.
  - In the next frame, pixel x = 80 has c = 6; pixel x = 639 has c = 0.
- Mode 5, 3 frames from reset:
  - Square at (0,0), then (1,1), then (2,2).
  - Pixel (x = 2, y = 2) in frame 3 is white; pixel (x = 40, y = 2) is blue.
- Bounce, with H_ACTIVE = 64, V_ACTIVE = 48, SQ = 32 and shrunken porches:
  - sx reaches 32 and holds for one frame with dx flipped, then decreases to 31.
  - sy holds at 16, then decreases.
- Reset pulse at hc = 300, vc = 200:
  - Outputs go to reset values asynchronously.
  - After release, next frame_start arrives 840000 clks after the first pix_ce.
  - With SYNC_POL = 1, hsync idles low.
